stream_check: RTL and testbench
===============================

# stream_check

Single-lane output stream checker sitting directly downstream of the core complex on one output port. Accepts words offered by the core complex over the port handshake, compares each against a preloaded expected stream, and reports per-lane progress, match count, first mismatch, overrun and stall status. One instance per output lane; a row wrapper aggregates the `done`/`pass` flags.

## Interface

- `DEPTH`, 39: maximum expected-stream length in words (`length` width is fixed at 6 bits, so DEPTH ≤ 63).
- `TIMEOUT`, 1000: cycles in RUN without an accepted word before `stall` sets.
- `clk`  in  1  system clock, all state on rising edge.
- `rst`  in  1  reset; one clock; reset is asynchronous and active-high.
- `length`  in  6  number of expected words; static while out of reset.
- `data`  in  [0:DEPTH-1] × 11 signed  expected words; static while out of reset.
- `rready`  in  1  producer (core complex `writeD` bit) has a valid word on `in`.
- `in`  in  11 signed  word offered by producer.
- `read`  out  1  one-cycle acknowledge; word on `in` consumed.
- `count`  out  6  words accepted so far.
- `correct`  out  6  accepted words equal to the expected word.
- `done`  out  1  `count == length` reached.
- `pass`  out  1  `done && correct == length && !extra`.
- `err_valid`  out  1  sticky; a mismatch has occurred.
- `err_idx`  out  6  index of first mismatching word.
- `err_got`  out  11 signed  value received at `err_idx`.
- `extra`  out  1  sticky; `rready` seen while in DONE.
- `stall`  out  1  sticky; TIMEOUT cycles in RUN without acceptance.

## Operation

- States: IDLE, RUN, ACK, DONE. Reset enters IDLE.
- IDLE (one cycle): latch `length` into internal `len`; go to DONE if `len == 0`, else RUN.
- RUN: when `rready` sampled high at an edge: set `read`, compare `in` to `data[count]`, increment `count`, increment `correct` on equality, go to ACK. Otherwise stay, increment stall counter.
- ACK: clear `read`; go to DONE if `count == len`, else RUN. `rready` ignored in ACK.
- DONE: `read` stays low forever; `rready` high at any edge sets `extra`. `done` high.
- First mismatch: capture `err_idx = count` (pre-increment) and `err_got = in`, set `err_valid`; later mismatches update only `correct`, not the capture.
- Comparison is full 11-bit signed equality; no saturation or wrap on values.
- `count`/`correct` never exceed `len`; no wrap possible since acceptance stops at DONE.
- Stall counter clears on every acceptance; saturates at TIMEOUT; `stall` sticky until reset; does not change state.

## Timing

- Reset values: `read=0`, `count=0`, `correct=0`, `done=0`, `pass=0`, `err_valid=0`, `err_idx=0`, `err_got=0`, `extra=0`, `stall=0`.
- All outputs registered; `done`/`pass` registered from state (no combinational path from `rready` or `in`).
- Acceptance: `rready` high at edge N in RUN → `read` high for exactly cycle N..N+1; `count` updated at edge N.
- Producer must drop or change `rready`/`in` after seeing `read`; checker guarantees no second acceptance at edge N+1 (ACK). Max throughput one word per 2 cycles.
- Last word at edge N → `done` high after edge N+1.
- `length == 0` → `done` and `pass` high after second edge following reset release.
- `rst` asserted mid-stream: all outputs clear immediately (asynchronous), stream restarts at word 0 after release.

## Test plan

- `length=3`, data {5,-7,1023}, producer offers 5,-7,1023 with rready held until read → three one-cycle `read` pulses 2 cycles apart, `count=3`, `correct=3`, `done=1`, `pass=1`, `err_valid=0`.
- `length=4`, data {1,2,3,4}, producer sends 1,9,3,-4 → `correct=2`, `err_valid=1`, `err_idx=1`, `err_got=9`, `pass=0`, `done=1`.
- `length=0`, rready low → `done=1`, `pass=1` two edges after reset release; `read` never asserts.
- `length=2`, both match, then producer raises rready again → no `read`, `extra=1`, `pass` drops to 0, `count` stays 2.
- TIMEOUT=10, `length=1`, rready low for 12 cycles then word offered → `stall=1` after 10 RUN cycles, word still accepted, `done=1`, `stall` stays 1.
- `length=5`, assert `rst` mid-cycle after 2 words accepted → outputs zero without clock edge; after release, resend full stream → `count=5`, `pass=1`.

Source files
------------

// File: rtl/stream_check_if.sv
// Producer-to-checker word handshake for one output lane.
// The producer holds rready/in until it sees the one-cycle read acknowledge.
interface stream_check_if;
  logic               rready;
  logic signed [10:0] in;
  logic               read;

  modport master (output rready, output in, input read);
  modport slave  (input rready, input in, output read);
endinterface

// File: rtl/stream_check.sv
// Single-lane output stream checker: accepts words over the handshake and compares
// each against a preloaded expected stream, reporting progress, errors, overrun and stall.
module stream_check #(
  parameter int unsigned DEPTH   = 39,
  parameter int unsigned TIMEOUT = 1000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         i_length,
  input  logic signed [10:0] i_data [0:DEPTH-1],
  stream_check_if.slave      s_if,
  output logic [5:0]         o_count,
  output logic [5:0]         o_correct,
  output logic               o_done,
  output logic               o_pass,
  output logic               o_err_valid,
  output logic [5:0]         o_err_idx,
  output logic signed [10:0] o_err_got,
  output logic               o_extra,
  output logic               o_stall
);

  localparam int unsigned SW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, RUN, ACK, DONE} state_t;

  state_t             r_state, w_state_n;
  logic [5:0]         r_len;
  logic [5:0]         r_count, r_correct;
  logic               r_read, r_done, r_pass;
  logic               r_err_valid, r_extra, r_stall;
  logic [5:0]         r_err_idx;
  logic signed [10:0] r_err_got;
  logic [SW-1:0]      r_stall_cnt;

  logic               w_accept, w_match, w_done_n, w_extra_n, w_pass_n;
  logic signed [10:0] w_exp;

  always_comb begin
    w_exp = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      if (r_count == 6'(k)) w_exp = i_data[k];
    end
  end

  assign w_match = (32'(r_count) < DEPTH) && (s_if.in == w_exp);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_n;
  end

  always_comb begin
    w_state_n = r_state;
    w_accept  = 1'b0;
    case (r_state)
      IDLE: w_state_n = (i_length == 6'd0) ? DONE : RUN;
      RUN: begin
        if (s_if.rready) begin
          w_accept  = 1'b1;
          w_state_n = ACK;
        end
      end
      ACK:     w_state_n = (r_count == r_len) ? DONE : RUN;
      DONE:    w_state_n = DONE;
      default: w_state_n = IDLE;
    endcase
  end

  // done/pass are registered one step behind the state so the final ACK
  // (and the zero-length IDLE->DONE path) report exactly one edge later.
  always_comb begin
    w_extra_n = r_extra | ((r_state == DONE) & s_if.rready);
    w_done_n  = (r_state == DONE) | ((r_state == ACK) & (r_count == r_len));
    w_pass_n  = w_done_n & (r_correct == r_len) & ~w_extra_n;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_len       <= '0;
      r_count     <= '0;
      r_correct   <= '0;
      r_read      <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_err_valid <= 1'b0;
      r_err_idx   <= '0;
      r_err_got   <= '0;
      r_extra     <= 1'b0;
      r_stall     <= 1'b0;
      r_stall_cnt <= '0;
    end else begin
      r_read  <= w_accept;
      r_done  <= w_done_n;
      r_pass  <= w_pass_n;
      r_extra <= w_extra_n;
      if (r_state == IDLE) r_len <= i_length;
      if (w_accept) begin
        r_count     <= r_count + 6'd1;
        r_stall_cnt <= '0;
        if (w_match) begin
          r_correct <= r_correct + 6'd1;
        end else if (!r_err_valid) begin
          r_err_valid <= 1'b1;
          r_err_idx   <= r_count;
          r_err_got   <= s_if.in;
        end
      end else if (r_state == RUN) begin
        if (r_stall_cnt < SW'(TIMEOUT)) r_stall_cnt <= r_stall_cnt + SW'(1);
        if (r_stall_cnt >= SW'(TIMEOUT - 1)) r_stall <= 1'b1;
      end
    end
  end

  assign s_if.read   = r_read;
  assign o_count     = r_count;
  assign o_correct   = r_correct;
  assign o_done      = r_done;
  assign o_pass      = r_pass;
  assign o_err_valid = r_err_valid;
  assign o_err_idx   = r_err_idx;
  assign o_err_got   = r_err_got;
  assign o_extra     = r_extra;
  assign o_stall     = r_stall;

endmodule

// File: tb/tb_stream_check.sv
// Directed self-checking bench for stream_check (TIMEOUT shortened to 10).
module tb_stream_check;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [5:0]         length = '0;
  logic signed [10:0] data [0:38];
  logic [5:0]         count, correct, err_idx;
  logic               done, pass, err_valid, extra, stall;
  logic signed [10:0] err_got;

  int unsigned n_asserts = 0;
  int unsigned n_fail    = 0;
  int unsigned cyc       = 0;
  int unsigned c0, c1, c2;

  stream_check_if u_if ();

  stream_check #(.DEPTH(39), .TIMEOUT(10)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_length   (length),
    .i_data     (data),
    .s_if       (u_if),
    .o_count    (count),
    .o_correct  (correct),
    .o_done     (done),
    .o_pass     (pass),
    .o_err_valid(err_valid),
    .o_err_idx  (err_idx),
    .o_err_got  (err_got),
    .o_extra    (extra),
    .o_stall    (stall)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic apply_reset(input logic [5:0] len);
    rst = 1'b1;
    u_if.rready = 1'b0;
    u_if.in = '0;
    length = len;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic clear_data();
    for (int i = 0; i < 39; i++) data[i] = '0;
  endtask

  // Offer one word and hold it until read; returns just after the accepting edge.
  task automatic send(input logic signed [10:0] w, output int unsigned at);
    logic got;
    got = 1'b0;
    u_if.in = w;
    u_if.rready = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      #1;
      if (u_if.read) begin
        got = 1'b1;
        break;
      end
    end
    check("send_ack_seen", {31'd0, got}, 32'd1);
    at = cyc;
    u_if.rready = 1'b0;
  endtask

  initial begin
    u_if.rready = 1'b0;
    u_if.in = '0;
    clear_data();

    // Exact match stream
    data[0] = 11'sd5; data[1] = -11'sd7; data[2] = 11'sd1023;
    apply_reset(6'd3);
    check("rst_read", {31'd0, u_if.read}, 32'd0);
    check("rst_count", {26'd0, count}, 32'd0);
    check("rst_correct", {26'd0, correct}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_pass", {31'd0, pass}, 32'd0);
    check("rst_err_valid", {31'd0, err_valid}, 32'd0);
    check("rst_err_idx", {26'd0, err_idx}, 32'd0);
    check("rst_err_got", 32'(err_got), 32'd0);
    check("rst_extra", {31'd0, extra}, 32'd0);
    check("rst_stall", {31'd0, stall}, 32'd0);
    send(11'sd5, c0);
    check("t1_count_after_first", {26'd0, count}, 32'd1);
    send(-11'sd7, c1);
    send(11'sd1023, c2);
    check("t1_spacing_a", c1 - c0, 32'd2);
    check("t1_spacing_b", c2 - c1, 32'd2);
    check("t1_done_not_yet", {31'd0, done}, 32'd0);
    @(posedge clk); #1;
    check("t1_read_one_cycle", {31'd0, u_if.read}, 32'd0);
    check("t1_done", {31'd0, done}, 32'd1);
    check("t1_count", {26'd0, count}, 32'd3);
    check("t1_correct", {26'd0, correct}, 32'd3);
    check("t1_pass", {31'd0, pass}, 32'd1);
    check("t1_err_valid", {31'd0, err_valid}, 32'd0);

    // Two mismatches; only the first is captured
    clear_data();
    data[0] = 11'sd1; data[1] = 11'sd2; data[2] = 11'sd3; data[3] = 11'sd4;
    apply_reset(6'd4);
    send(11'sd1, c0);
    send(11'sd9, c0);
    send(11'sd3, c0);
    send(-11'sd4, c0);
    @(posedge clk); #1;
    check("t2_correct", {26'd0, correct}, 32'd2);
    check("t2_err_valid", {31'd0, err_valid}, 32'd1);
    check("t2_err_idx", {26'd0, err_idx}, 32'd1);
    check("t2_err_got", 32'(err_got), 32'd9);
    check("t2_pass", {31'd0, pass}, 32'd0);
    check("t2_done", {31'd0, done}, 32'd1);

    // Zero-length stream
    clear_data();
    apply_reset(6'd0);
    @(posedge clk); #1;
    check("t3_done_edge1", {31'd0, done}, 32'd0);
    check("t3_read_edge1", {31'd0, u_if.read}, 32'd0);
    @(posedge clk); #1;
    check("t3_done_edge2", {31'd0, done}, 32'd1);
    check("t3_pass_edge2", {31'd0, pass}, 32'd1);
    check("t3_read_edge2", {31'd0, u_if.read}, 32'd0);

    // Overrun after completion
    data[0] = 11'sd10; data[1] = -11'sd1;
    apply_reset(6'd2);
    send(11'sd10, c0);
    send(-11'sd1, c0);
    @(posedge clk); #1;
    check("t4_pass_before", {31'd0, pass}, 32'd1);
    u_if.in = 11'sd0;
    u_if.rready = 1'b1;
    @(posedge clk); #1;
    check("t4_extra", {31'd0, extra}, 32'd1);
    check("t4_no_read", {31'd0, u_if.read}, 32'd0);
    check("t4_pass_drop", {31'd0, pass}, 32'd0);
    check("t4_count", {26'd0, count}, 32'd2);
    u_if.rready = 1'b0;

    // Stall timeout with a single late word
    clear_data();
    data[0] = 11'sd100;
    apply_reset(6'd1);
    @(posedge clk); #1;
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1;
    end
    check("t5_stall_at_9", {31'd0, stall}, 32'd0);
    @(posedge clk); #1;
    check("t5_stall_at_10", {31'd0, stall}, 32'd1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    send(11'sd100, c0);
    @(posedge clk); #1;
    check("t5_done", {31'd0, done}, 32'd1);
    check("t5_pass", {31'd0, pass}, 32'd1);
    check("t5_stall_sticky", {31'd0, stall}, 32'd1);

    // Asynchronous reset mid-stream, then full resend
    clear_data();
    for (int i = 0; i < 5; i++) data[i] = 11'(i + 1);
    apply_reset(6'd5);
    send(11'sd1, c0);
    send(11'sd2, c0);
    check("t6_count_mid", {26'd0, count}, 32'd2);
    #2 rst = 1'b1;
    #1;
    check("t6_async_count", {26'd0, count}, 32'd0);
    check("t6_async_correct", {26'd0, correct}, 32'd0);
    check("t6_async_read", {31'd0, u_if.read}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) send(11'(i + 1), c0);
    @(posedge clk); #1;
    check("t6_count", {26'd0, count}, 32'd5);
    check("t6_pass", {31'd0, pass}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
